// File: rtl/fifo_drain_packer.sv
// Read-domain drain engine for fifo_flush_async_grey: pops the FIFO one nibble per
// cycle, packs nibbles into 32-bit words and hands them out over valid/ready.
module fifo_drain_packer #(
  parameter int NIBBLES = 8
) (
  input  logic                 rclock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 fifo_empty_i,
  input  logic [3:0]           fifo_curr_i,
  output logic                 fifo_flush_o,
  output logic                 word_valid_o,
  output logic [4*NIBBLES-1:0] word_data_o,
  output logic [3:0]           word_count_o,
  input  logic                 word_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);
  typedef enum logic [1:0] {IDLE, DRAIN, EMIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [NIBBLES-1:0][3:0] acc;
  logic [3:0]              nib_cnt, nib_nxt;
  logic                    cap_q, clr_acc;

  // Count a pop still in flight so the word never overflows.
  assign nib_nxt      = nib_cnt + {3'b0, cap_q};
  assign fifo_flush_o = (state == DRAIN) && !fifo_empty_i && (nib_nxt < 4'(NIBBLES));

  assign word_data_o  = word_valid_o ? acc : '0;
  assign word_count_o = word_valid_o ? nib_cnt : 4'd0;

  always_comb begin
    state_nxt    = state;
    clr_acc      = 1'b0;
    word_valid_o = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state != IDLE);
    case (state)
      IDLE: if (start_i) begin
        state_nxt = DRAIN;
        clr_acc   = 1'b1;
      end
      DRAIN: begin
        if (nib_nxt == 4'(NIBBLES))
          state_nxt = EMIT;
        else if (fifo_empty_i && !cap_q)
          state_nxt = (nib_cnt != 4'd0) ? EMIT : DONE;
      end
      EMIT: begin
        word_valid_o = 1'b1;
        if (word_ready_i) begin
          state_nxt = DRAIN;
          clr_acc   = 1'b1;
        end
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      nib_cnt <= 4'd0;
      cap_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cap_q <= fifo_flush_o;
      if (clr_acc)    nib_cnt <= 4'd0;
      else if (cap_q) nib_cnt <= nib_nxt;
    end
  end

  // Slot k takes the returned nibble when it is the next free slot.
  always_ff @(posedge rclock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (clr_acc)                          acc[k] <= 4'd0;
        else if (cap_q && nib_cnt == 4'(k))   acc[k] <= fifo_curr_i;
      end
    end
  end
endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer: queue-based FIFO model, word scoreboard built from
// the nibble stream, per-cycle protocol checks and directed timing checks.
module tb_fifo_drain_packer;
  logic        rclock = 1'b0;
  logic        reset;
  logic        start_i;
  logic        fifo_empty_i = 1'b1;
  logic [3:0]  fifo_curr_i  = 4'd0;
  logic        fifo_flush_o;
  logic        word_valid_o;
  logic [31:0] word_data_o;
  logic [3:0]  word_count_o;
  logic        word_ready_i;
  logic        busy_o;
  logic        done_o;

  fifo_drain_packer #(.NIBBLES(8)) dut (
    .rclock(rclock), .reset(reset), .start_i(start_i),
    .fifo_empty_i(fifo_empty_i), .fifo_curr_i(fifo_curr_i),
    .fifo_flush_o(fifo_flush_o), .word_valid_o(word_valid_o),
    .word_data_o(word_data_o), .word_count_o(word_count_o),
    .word_ready_i(word_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 rclock = ~rclock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0]  fifo_q[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_cnt[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_cnt[$];

  int start_cyc, first_flush, last_flush, run_flush, run_valid, first_valid;
  int hs_cyc, done_cyc, run_done;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_cnt = '0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  always @(posedge rclock) cyc <= cyc + 1;

  // FIFO model: nibble appears on fifo_curr_i the cycle after a flush pulse.
  always @(posedge rclock) begin
    if (fifo_flush_o && fifo_q.size() > 0) fifo_curr_i <= fifo_q.pop_front();
    fifo_empty_i <= (fifo_q.size() == 0);
  end

  // Push nibbles into the FIFO model and, optionally, the words they must form.
  task automatic load(input int n, input int first, input bit expect_words);
    logic [31:0] w;
    logic [3:0]  c;
    for (int i = 0; i < n; i++) fifo_q.push_back(4'((first + i) % 16));
    if (expect_words)
      for (int i = 0; i < n; i += 8) begin
        w = '0;
        c = '0;
        for (int j = i; j < n && j < i + 8; j++) begin
          w = w | (32'((first + j) % 16) << (4 * (j - i)));
          c = c + 4'd1;
        end
        exp_data.push_back(w);
        exp_cnt.push_back(c);
      end
  endtask

  always @(negedge rclock) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (start_i && !busy_o) begin
        start_cyc = cyc; run_flush = 0; first_flush = -1; last_flush = -1;
        run_valid = 0; first_valid = -1; hs_cyc = -1; done_cyc = -1; run_done = 0;
      end
      if (fifo_flush_o) begin
        chk(busy_o && !word_valid_o && !done_o, "flush_legal", {word_valid_o, done_o}, 0);
        if (first_flush < 0) first_flush = cyc;
        last_flush = cyc;
        run_flush++;
      end
      if (!word_valid_o) chk(word_count_o == 4'd0, "count_idle", word_count_o, 0);
      if (prev_valid && !prev_ready)
        chk(word_valid_o && word_data_o == prev_data && word_count_o == prev_cnt,
            "hold_stable", word_data_o, prev_data);
      if (word_valid_o) begin
        run_valid++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (word_valid_o && word_ready_i) begin
        if (exp_data.size() == 0) chk(1'b0, "extra_word", word_data_o, 0);
        else begin
          chk(word_data_o == exp_data[0], "word_data", word_data_o, exp_data[0]);
          chk(word_count_o == exp_cnt[0], "word_count", word_count_o, exp_cnt[0]);
          void'(exp_data.pop_front());
          void'(exp_cnt.pop_front());
        end
        got_data.push_back(word_data_o);
        got_cnt.push_back(word_count_o);
        hs_cyc = cyc;
      end
      if (done_o) begin
        run_done++;
        done_cyc = cyc;
        chk(exp_data.size() == 0, "done_words_left", exp_data.size(), 0);
      end
      prev_valid = word_valid_o;
      prev_ready = word_ready_i;
      prev_data  = word_data_o;
      prev_cnt   = word_count_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge rclock);
    #1;
  endtask

  // Start a drain and run until done_o; ready goes high after `hold` stalled valid cycles.
  task automatic run_drain(input int hold, input bit repulse);
    int  vcnt = 0;
    bit  seen = 1'b0;
    start_i = 1'b1;
    word_ready_i = (hold == 0);
    @(posedge rclock); #1;
    start_i = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge rclock);
      if (done_o) seen = 1'b1;
      if (word_valid_o) vcnt = word_ready_i ? 0 : vcnt + 1;
      @(posedge rclock); #1;
      word_ready_i = (vcnt >= hold);
      start_i = repulse && busy_o && (t == 2 || word_valid_o);
    end
    start_i = 1'b0;
    chk(seen, "done_seen", seen, 1);
    chk(!busy_o, "idle_after_done", busy_o, 0);
  endtask

  int base, nv, nd;

  initial begin
    reset = 1'b1; start_i = 1'b0; word_ready_i = 1'b0;
    idle(2);
    chk({fifo_flush_o, word_valid_o, busy_o, done_o} == 4'b0, "reset_ctl",
        {fifo_flush_o, word_valid_o, busy_o, done_o}, 0);
    chk(word_data_o == 32'h0 && word_count_o == 4'h0, "reset_word", word_data_o, 0);
    #2 reset = 1'b0;
    idle(1);

    // 8 nibbles, ready always high
    load(8, 1, 1'b1); idle(2);
    base = got_data.size();
    run_drain(0, 1'b0);
    chk(got_data.size() - base == 1, "t8_words", got_data.size() - base, 1);
    chk(got_data[base] == 32'h87654321, "t8_data", got_data[base], 32'h87654321);
    chk(got_cnt[base] == 4'd8, "t8_count", got_cnt[base], 8);
    chk(run_flush == 8, "t8_flushes", run_flush, 8);
    chk(last_flush - first_flush + 1 == 8, "t8_flush_run", last_flush - first_flush + 1, 8);
    chk(first_valid - start_cyc == 10, "t8_valid_lat", first_valid - start_cyc, 10);
    chk(done_cyc - hs_cyc == 2, "t8_done_lat", done_cyc - hs_cyc, 2);
    idle(2);

    // 11 nibbles: full word then a 3-nibble partial
    load(11, 1, 1'b1); idle(2);
    base = got_data.size();
    run_drain(0, 1'b0);
    chk(got_data.size() - base == 2, "t11_words", got_data.size() - base, 2);
    chk(got_data[base] == 32'h87654321, "t11_data0", got_data[base], 32'h87654321);
    chk(got_cnt[base] == 4'd8, "t11_count0", got_cnt[base], 8);
    chk(got_data[base+1] == 32'h00000BA9, "t11_data1", got_data[base+1], 32'hBA9);
    chk(got_cnt[base+1] == 4'd3, "t11_count1", got_cnt[base+1], 3);
    chk(run_flush == 11, "t11_flushes", run_flush, 11);
    chk(run_done == 1, "t11_done_once", run_done, 1);
    idle(2);

    // empty FIFO
    base = got_data.size();
    run_drain(0, 1'b0);
    chk(run_flush == 0, "empty_flushes", run_flush, 0);
    chk(run_valid == 0, "empty_valid", run_valid, 0);
    chk(done_cyc - start_cyc == 2, "empty_done_lat", done_cyc - start_cyc, 2);
    chk(got_data.size() == base, "empty_words", got_data.size() - base, 0);
    idle(2);

    // backpressure: 20 stalled cycles, handshake on the 21st
    load(8, 1, 1'b1); idle(2);
    base = got_data.size();
    run_drain(20, 1'b0);
    chk(run_valid == 21, "bp_valid_cycles", run_valid, 21);
    chk(hs_cyc - first_valid == 20, "bp_hs_cycle", hs_cyc - first_valid, 20);
    chk(got_data[base] == 32'h87654321, "bp_data", got_data[base], 32'h87654321);
    chk(run_flush == 8, "bp_flushes", run_flush, 8);
    idle(2);

    // start re-pulsed during DRAIN and EMIT
    load(11, 1, 1'b1); idle(2);
    base = got_data.size();
    run_drain(2, 1'b1);
    chk(got_data.size() - base == 2, "rp_words", got_data.size() - base, 2);
    chk(got_data[base] == 32'h87654321, "rp_data0", got_data[base], 32'h87654321);
    chk(got_data[base+1] == 32'h00000BA9, "rp_data1", got_data[base+1], 32'hBA9);
    chk(got_cnt[base+1] == 4'd3, "rp_count1", got_cnt[base+1], 3);
    chk(run_flush == 11, "rp_flushes", run_flush, 11);
    chk(run_done == 1, "rp_done_once", run_done, 1);
    chk(done_cyc - hs_cyc == 2, "rp_done_lat", done_cyc - hs_cyc, 2);
    idle(2);

    // asynchronous reset after 3 captures abandons the partial word
    load(5, 1, 1'b0); idle(2);
    start_i = 1'b1; word_ready_i = 1'b1;
    @(posedge rclock); #1;
    start_i = 1'b0;
    repeat (4) @(posedge rclock);
    #1;
    chk(busy_o, "rst_mid_busy", busy_o, 1);
    #1 reset = 1'b1;
    #1;
    chk({fifo_flush_o, word_valid_o, busy_o, done_o} == 4'b0, "rst_async_ctl",
        {fifo_flush_o, word_valid_o, busy_o, done_o}, 0);
    chk(word_data_o == 32'h0 && word_count_o == 4'h0, "rst_async_word", word_data_o, 0);
    fifo_q.delete();
    repeat (2) @(posedge rclock);
    #3 reset = 1'b0;
    nv = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclock);
      if (word_valid_o) nv++;
      if (done_o) nd++;
    end
    chk(nv == 0 && nd == 0, "rst_no_followup", {nv[15:0], nd[15:0]}, 0);
    idle(1);
    load(1, 9, 1'b1); idle(2);
    base = got_data.size();
    run_drain(0, 1'b0);
    chk(got_data[base] == 32'h00000009, "rst_next_data", got_data[base], 32'h9);
    chk(got_cnt[base] == 4'd1, "rst_next_count", got_cnt[base], 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_drain_packer.md
Name: fifo_drain_packer

Overview:
- Read-side consumer of fifo_flush_async_grey, in the rclock domain.
- On a drain request it pulses the FIFO's flush input nibble by nibble.
- It captures each registered 4-bit output, packs 8 nibbles into a 32-bit word and presents the word on a valid/ready output port.
- A final partial word is emitted with its nibble count, then done_o pulses.

Parameters:
- NIBBLES, 8, nibbles per output word; fixed at 8 (32/4), port widths depend on it.

Ports:
- rclock  input  1  read-domain clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start_i  input  1  drain request; sampled only in IDLE
- fifo_empty_i  input  1  from FIFO fifo_empty_o
- fifo_curr_i  input  4  from FIFO fifo_curr_o; the registered read nibble
- fifo_flush_o  output  1  to FIFO fifo_flush_i; one nibble popped per high cycle
- word_valid_o  output  1  output word valid
- word_data_o  output  32  packed word; nibble k in bits [4k+3:4k]
- word_count_o  output  4  number of valid nibbles in word_data_o (1..8)
- word_ready_i  input  1  downstream accepts word when high with valid
- busy_o  output  1  high in any state other than IDLE
- done_o  output  1  one-cycle pulse at end of drain

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs 0; accumulator, nib_cnt and cap_q cleared.
  - A reset mid-drain abandons the partial word. No word and no done pulse are produced.
- FIFO timing contract: the FIFO returns the popped nibble on fifo_curr_i in the cycle after fifo_flush_o was high.
  - cap_q is a register loaded with fifo_flush_o each cycle.
  - When cap_q=1, fifo_curr_i is written into accumulator slot nib_cnt, then nib_cnt increments.
- fifo_flush_o is combinational: (state==DRAIN) && !fifo_empty_i && (nib_cnt + cap_q < 8).
  - Never high in IDLE, EMIT or DONE. Never pops a nibble that would overflow the current word.
- States:
  - IDLE: start_i=1 moves to DRAIN. Accumulator is zeroed, nib_cnt=0.
  - DRAIN: captures as above. Transitions are evaluated after the capture update.
    - nib_cnt==8 moves to EMIT.
    - fifo_empty_i=1, cap_q=0 and nib_cnt>0 moves to EMIT (partial word; unused upper nibbles are 0).
    - fifo_empty_i=1, cap_q=0 and nib_cnt==0 moves to DONE.
  - EMIT: word_valid_o=1. word_data_o and word_count_o=nib_cnt are held stable until word_ready_i=1.
    - On handshake: accumulator is zeroed, nib_cnt=0, next state DRAIN.
    - Backpressure of any length is legal. No FIFO pops occur while waiting.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Throughput: one nibble per cycle when the FIFO is non-empty, so a full word is ready 9 cycles after entering DRAIN.
  - word_valid_o rises in the cycle after the 8th capture.
- start_i while busy_o=1 is ignored.
- fifo_empty_i going low during EMIT has no effect until the state returns to DRAIN.
- An empty FIFO at start produces no words: DRAIN to DONE in one cycle, done_o 2 cycles after start.
- word_count_o is 0 whenever word_valid_o=0.

Test Plan:
- Reset mid-drain, asserted asynchronously after 3 captures:
  - outputs go 0 immediately; no word or done_o follows.
  - a subsequent start_i with 1 nibble 0x9 gives data 0x00000009, count 1.
- FIFO preloaded with 0x1..0x8, start_i pulse, word_ready_i=1:
  - fifo_flush_o high 8 consecutive cycles.
  - one word 0x87654321 with count 8.
  - done_o pulses 2 cycles after the handshake; busy_o then 0.
- 11 nibbles 0x1..0xB:
  - first word 0x87654321 count 8.
  - second word 0x00000BA9 count 3.
  - exactly 11 flush pulses, then done_o.
- Empty FIFO, start_i:
  - no fifo_flush_o and no word_valid_o.
  - done_o pulses 2 cycles after start.
- 8 nibbles, word_ready_i held low 20 cycles:
  - word_valid_o, data and count stable for all 20 cycles.
  - fifo_flush_o stays 0 throughout.
  - handshake on cycle 21.
- start_i re-pulsed during DRAIN and EMIT:
  - ignored; output words and done_o are identical to the single-start run.
